// File: rtl/ysyx_22050550_axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-channel arbiter: FSM states, burst and response codes.
package ysyx_22050550_axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_22050550_axi_rd_arbiter_if.sv
// AXI read-channel bundle (AR + R); master drives requests, slave answers with data.
interface ysyx_22050550_axi_rd_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;

    modport master (
        output ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        input  ar_ready, r_valid, r_data, r_resp, r_last
    );

    modport slave (
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        output ar_ready, r_valid, r_data, r_resp, r_last
    );
endinterface

// File: rtl/ysyx_22050550_rr_pick2.sv
// Two-requester picker: round-robin against last_gnt, or fixed priority with requester 1 on top.
module ysyx_22050550_rr_pick2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt
);
    always_comb begin
        gnt = req[1];
        if (req == 2'b11) begin
            gnt = RR_EN ? ~last_gnt : 1'b1;
        end
    end
endmodule

// File: rtl/ysyx_22050550_axi_rd_arbiter.sv
// Arbitrates the AR/R channels of two read masters onto one AXI slave port,
// one transaction at a time, and flags R-channel length violations.
module ysyx_22050550_axi_rd_arbiter
    import ysyx_22050550_axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter bit RR_EN  = 1'b1
) (
    input  logic clock,
    input  logic reset,
    ysyx_22050550_axi_rd_arbiter_if.slave  m0,
    ysyx_22050550_axi_rd_arbiter_if.slave  m1,
    ysyx_22050550_axi_rd_arbiter_if.master s,
    output logic busy,
    output logic proto_err
);
    state_e            state;
    logic              gnt;
    logic              last_gnt;
    logic [7:0]        beat_cnt;
    logic [7:0]        len_q;
    logic              pick;
    logic              r_hs;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] r_data;

    ysyx_22050550_rr_pick2 #(.RR_EN(RR_EN)) u_pick (
        .req      ({m1.ar_valid, m0.ar_valid}),
        .last_gnt (last_gnt),
        .gnt      (pick)
    );

    assign r_hs = (state == DATA) && s.r_valid && s.r_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;
            beat_cnt  <= '0;
            len_q     <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0.ar_valid || m1.ar_valid) begin
                        gnt   <= pick;
                        len_q <= pick ? m1.ar_len : m0.ar_len;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (s.ar_ready) begin
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        if (beat_cnt != 8'hff) begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                        // Early last and missing last both compare against the count before this beat.
                        if (s.r_last) begin
                            last_gnt <= gnt;
                            state    <= IDLE;
                            if (beat_cnt != len_q) begin
                                proto_err <= 1'b1;
                            end
                        end else if (beat_cnt == len_q) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        addr_sel   = gnt ? m1.ar_addr : m0.ar_addr;
        r_data     = s.r_data;

        s.ar_valid = (state == ADDR);
        s.ar_addr  = addr_sel;
        s.ar_len   = gnt ? m1.ar_len   : m0.ar_len;
        s.ar_size  = gnt ? m1.ar_size  : m0.ar_size;
        s.ar_burst = gnt ? m1.ar_burst : m0.ar_burst;
        s.r_ready  = (state == DATA) && (gnt ? m1.r_ready : m0.r_ready);

        m0.ar_ready = (state == ADDR) && !gnt && s.ar_ready;
        m1.ar_ready = (state == ADDR) &&  gnt && s.ar_ready;

        m0.r_valid = (state == DATA) && !gnt && s.r_valid;
        m0.r_data  = r_data;
        m0.r_resp  = s.r_resp;
        m0.r_last  = s.r_last;

        m1.r_valid = (state == DATA) &&  gnt && s.r_valid;
        m1.r_data  = r_data;
        m1.r_resp  = s.r_resp;
        m1.r_last  = s.r_last;

        busy = (state != IDLE);
    end
endmodule
